// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types, constants and helpers for the APB requester
// Purpose: state encoding, word-alignment mask and strobe-width helper used
//          by apb_master.
// Ports:   none (package).
package apb_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETUP  = 2'd1,
      ACCESS = 2'd2,
      RESP   = 2'd3
   } apb_state_t;

   // Byte-offset bits that must be zero for a word-aligned access.
   localparam logic [1:0] ALIGN_MASK = 2'b11;

   function automatic int strb_width(input int data_width);
      return data_width / 8;
   endfunction

endpackage

// File: rtl/apb_watchdog.sv
// rtl/apb_watchdog.sv - bounded wait-state counter for the APB ACCESS phase
// Purpose: counts ACCESS cycles with pready low and flags expiry on the cycle
//          in which the count would reach TIMEOUT. TIMEOUT=0 disables it.
// Ports:   pclk, presetn  clock / async active-low reset
//          clear          zero the count (transfer entering SETUP)
//          count_en       ACCESS cycle with pready low
//          expired        abort this cycle (combinational, qualified by count_en)
module apb_watchdog #(
   parameter int TIMEOUT = 16
) (
   input  logic pclk,
   input  logic presetn,
   input  logic clear,
   input  logic count_en,
   output logic expired
);

   generate
      if (TIMEOUT == 0) begin : g_off
         assign expired = 1'b0;
      end else begin : g_on
         localparam int CW = $clog2(TIMEOUT + 1);
         logic [CW-1:0] count;

         always_ff @(posedge pclk or negedge presetn) begin
            if (!presetn) begin
               count <= '0;
            end else if (clear) begin
               count <= '0;
            end else if (count_en) begin
               count <= count + CW'(1);
            end
         end

         // The current waiting cycle is number count+1; when that equals
         // TIMEOUT the transfer is abandoned. A pready in that same cycle
         // deasserts count_en, so the response wins.
         assign expired = count_en && (count == CW'(TIMEOUT - 1));
      end
   endgenerate

endmodule

// File: rtl/apb_master.sv
// rtl/apb_master.sv - single-outstanding CPU to APB requester
// Purpose: converts a held CPU load/store request into an APB SETUP/ACCESS
//          transfer, rejects misaligned addresses without a bus cycle, and
//          aborts a transfer whose responder stalls for TIMEOUT wait states.
// Ports:   pclk, presetn                      clock / async active-low reset
//          cpu_req/we/addr/wdata/strb         CPU request (held until cpu_done)
//          cpu_rdata/cpu_done/cpu_err         CPU response, valid on cpu_done
//          paddr/pdata/pwrite/pstb/psel/penable  APB request signals
//          prdata/pready/perr                 APB responder signals
module apb_master
   import apb_pkg::*;
#(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int TIMEOUT    = 16
) (
   input  logic                              pclk,
   input  logic                              presetn,
   input  logic                              cpu_req,
   input  logic                              cpu_we,
   input  logic [ADDR_WIDTH-1:0]             cpu_addr,
   input  logic [DATA_WIDTH-1:0]             cpu_wdata,
   input  logic [strb_width(DATA_WIDTH)-1:0] cpu_strb,
   output logic [DATA_WIDTH-1:0]             cpu_rdata,
   output logic                              cpu_done,
   output logic                              cpu_err,
   output logic [ADDR_WIDTH-1:0]             paddr,
   output logic [DATA_WIDTH-1:0]             pdata,
   input  logic [DATA_WIDTH-1:0]             prdata,
   output logic                              psel,
   output logic                              penable,
   output logic                              pwrite,
   output logic [strb_width(DATA_WIDTH)-1:0] pstb,
   input  logic                              pready,
   input  logic                              perr
);

   localparam int SW = strb_width(DATA_WIDTH);

   apb_state_t              state, state_nxt;
   logic [ADDR_WIDTH-1:0]   addr_q;
   logic [DATA_WIDTH-1:0]   wdata_q;
   logic [DATA_WIDTH-1:0]   rdata_q;
   logic [SW-1:0]           strb_q;
   logic                    we_q;
   logic                    err_q;
   logic                    misaligned;
   logic                    start;
   logic                    wd_expired;

   assign misaligned = |(cpu_addr[1:0] & ALIGN_MASK);
   assign start      = (state == IDLE) && cpu_req && !misaligned;

   apb_watchdog #(
      .TIMEOUT (TIMEOUT)
   ) u_watchdog (
      .pclk     (pclk),
      .presetn  (presetn),
      .clear    (start),
      .count_en ((state == ACCESS) && !pready),
      .expired  (wd_expired)
   );

   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      psel      = 1'b0;
      penable   = 1'b0;
      cpu_done  = 1'b0;
      case (state)
         IDLE: begin
            if (cpu_req) begin
               state_nxt = misaligned ? RESP : SETUP;
            end
         end
         SETUP: begin
            psel      = 1'b1;
            state_nxt = ACCESS;
         end
         ACCESS: begin
            psel    = 1'b1;
            penable = 1'b1;
            if (pready || wd_expired) begin
               state_nxt = RESP;
            end
         end
         RESP: begin
            cpu_done  = 1'b1;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Request registers feed the bus for all of SETUP/ACCESS; response
   // registers only change on the way into RESP, so they hold between
   // completions.
   always_ff @(posedge pclk or negedge presetn) begin
      if (!presetn) begin
         addr_q  <= '0;
         wdata_q <= '0;
         we_q    <= 1'b0;
         strb_q  <= '0;
         rdata_q <= '0;
         err_q   <= 1'b0;
      end else begin
         if ((state == IDLE) && cpu_req) begin
            if (misaligned) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end else begin
               addr_q  <= cpu_addr;
               wdata_q <= cpu_wdata;
               we_q    <= cpu_we;
               strb_q  <= cpu_we ? cpu_strb : '0;
            end
         end
         if (state == ACCESS) begin
            if (pready) begin
               rdata_q <= we_q ? '0 : prdata;
               err_q   <= perr;
            end else if (wd_expired) begin
               rdata_q <= '0;
               err_q   <= 1'b1;
            end
         end
      end
   end

   assign paddr     = addr_q;
   assign pdata     = wdata_q;
   assign pwrite    = we_q;
   assign pstb      = strb_q;
   assign cpu_rdata = rdata_q;
   assign cpu_err   = err_q;

endmodule

// File: tb/tb_apb_master.sv
// tb/tb_apb_master.sv - self-checking bench for apb_master
module tb_apb_master;

   localparam int TMO = 16;

   logic        pclk = 1'b0;
   logic        presetn = 1'b0;
   logic        cpu_req = 1'b0;
   logic        cpu_we = 1'b0;
   logic [31:0] cpu_addr = '0;
   logic [31:0] cpu_wdata = '0;
   logic [3:0]  cpu_strb = '0;
   logic [31:0] cpu_rdata;
   logic        cpu_done;
   logic        cpu_err;
   logic [31:0] paddr;
   logic [31:0] pdata;
   logic [31:0] prdata;
   logic        psel;
   logic        penable;
   logic        pwrite;
   logic [3:0]  pstb;
   logic        pready;
   logic        perr;

   int          n_cmp = 0;
   int          n_bad = 0;

   // responder configuration for the current transfer
   int          waits_cur = 0;
   logic        perr_cur = 1'b0;
   int          acc_cnt = 0;
   logic [31:0] mem [64];
   logic [31:0] shadow [64];

   always #5 pclk = ~pclk;

   apb_master #(
      .ADDR_WIDTH (32),
      .DATA_WIDTH (32),
      .TIMEOUT    (TMO)
   ) dut (
      .pclk      (pclk),
      .presetn   (presetn),
      .cpu_req   (cpu_req),
      .cpu_we    (cpu_we),
      .cpu_addr  (cpu_addr),
      .cpu_wdata (cpu_wdata),
      .cpu_strb  (cpu_strb),
      .cpu_rdata (cpu_rdata),
      .cpu_done  (cpu_done),
      .cpu_err   (cpu_err),
      .paddr     (paddr),
      .pdata     (pdata),
      .prdata    (prdata),
      .psel      (psel),
      .penable   (penable),
      .pwrite    (pwrite),
      .pstb      (pstb),
      .pready    (pready),
      .perr      (perr)
   );

   // Behavioural responder: sram below 0x400, a uart returning 0x41 at 0x400.
   always_comb begin
      pready = psel && penable && (acc_cnt >= waits_cur);
      perr   = pready && perr_cur;
      prdata = paddr[10] ? 32'h41 : mem[paddr[7:2]];
   end

   always @(posedge pclk) begin
      acc_cnt <= (psel && penable && !pready) ? acc_cnt + 1 : 0;
      if (psel && penable && pready && pwrite && !perr && !paddr[10]) begin
         for (int b = 0; b < 4; b++) begin
            if (pstb[b]) mem[paddr[7:2]][8*b +: 8] <= pdata[8*b +: 8];
         end
      end
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   // One CPU transfer; called at a negedge with the DUT in IDLE.
   task automatic do_xfer(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [3:0] strb, input int waits, input logic pe);
      logic        mis, to, done;
      int          exp_lat, cyc, nsel, bad, first_sel, first_en;
      logic [31:0] exp_rd;
      logic        exp_err;
      logic [3:0]  exp_stb;

      mis     = (addr[1:0] != 2'b00);
      to      = !mis && (waits >= TMO);
      exp_lat = mis ? 1 : (to ? 2 + TMO : 3 + waits);
      exp_err = mis || to || pe;
      exp_rd  = (mis || to || we) ? 32'h0 : (addr[10] ? 32'h41 : shadow[addr[7:2]]);
      exp_stb = we ? strb : 4'h0;

      waits_cur = waits;
      perr_cur  = pe;
      cpu_req   = 1'b1;
      cpu_we    = we;
      cpu_addr  = addr;
      cpu_wdata = wdata;
      cpu_strb  = strb;

      cyc = 0; done = 1'b0; nsel = 0; bad = 0; first_sel = 0; first_en = 0;
      while (!done && cyc < 40) begin
         @(negedge pclk);
         cyc++;
         if (psel) begin
            nsel++;
            if (first_sel == 0) first_sel = cyc;
            if (penable && first_en == 0) first_en = cyc;
            if (paddr !== addr || pwrite !== we || pstb !== exp_stb || (we && pdata !== wdata))
               bad++;
         end
         if (cpu_done) done = 1'b1;
      end
      cpu_req = 1'b0;

      check("latency", cyc, exp_lat);
      check("cpu_err", cpu_err, exp_err);
      check("cpu_rdata", cpu_rdata, exp_rd);
      check("psel_cycles", nsel, mis ? 0 : exp_lat - 1);
      check("bus_stable", bad, 0);
      if (!mis) begin
         check("psel_rise", first_sel, 1);
         check("penable_rise", first_en, 2);
      end
      @(negedge pclk);
      check("done_single", {cpu_done, psel, penable}, 3'b000);
      check("rdata_hold", cpu_rdata, exp_rd);

      if (we && !exp_err && !addr[10]) begin
         for (int b = 0; b < 4; b++) begin
            if (strb[b]) shadow[addr[7:2]][8*b +: 8] = wdata[8*b +: 8];
         end
      end
   endtask

   initial begin
      logic [31:0] a;
      int          w, r;
      logic        we_r;

      for (int i = 0; i < 64; i++) begin
         mem[i]    = '0;
         shadow[i] = '0;
      end

      #1;
      check("rst_bus", {30'd0, psel, penable}, 32'h0);
      check("rst_cpu", {30'd0, cpu_done, cpu_err}, 32'h0);
      check("rst_paddr", paddr, 32'h0);
      check("rst_rdata", cpu_rdata, 32'h0);
      repeat (2) @(negedge pclk);
      presetn = 1'b1;
      @(negedge pclk);

      // directed cases
      do_xfer(1'b1, 32'h100, 32'hDEADBEEF, 4'hF, 0, 1'b0);
      do_xfer(1'b0, 32'h100, 32'h0, 4'hF, 0, 1'b0);
      do_xfer(1'b0, 32'h400, 32'h0, 4'h0, 3, 1'b0);
      do_xfer(1'b0, 32'h040, 32'h0, 4'h0, 0, 1'b1);
      do_xfer(1'b0, 32'h102, 32'h0, 4'h0, 0, 1'b0);
      do_xfer(1'b0, 32'h100, 32'h0, 4'h0, 255, 1'b0);
      do_xfer(1'b0, 32'h100, 32'h0, 4'h0, TMO - 1, 1'b1);
      do_xfer(1'b0, 32'h100, 32'h0, 4'h0, TMO - 1, 1'b0);
      do_xfer(1'b1, 32'h104, 32'h11223344, 4'h5, 1, 1'b0);
      do_xfer(1'b0, 32'h104, 32'h0, 4'h0, 2, 1'b0);

      // reset in the middle of ACCESS
      waits_cur = 255;
      perr_cur  = 1'b0;
      cpu_req   = 1'b1;
      cpu_we    = 1'b0;
      cpu_addr  = 32'h010;
      repeat (4) @(negedge pclk);
      check("pre_rst_access", {30'd0, psel, penable}, 32'h3);
      presetn = 1'b0;
      #1;
      check("rst_mid_bus", {30'd0, psel, penable}, 32'h0);
      check("rst_mid_cpu", {29'd0, cpu_done, cpu_err, 1'b0}, 32'h0);
      check("rst_mid_rdata", cpu_rdata, 32'h0);
      cpu_req = 1'b0;
      for (int i = 0; i < 3; i++) begin
         @(negedge pclk);
         check("rst_no_done", {31'd0, cpu_done}, 32'h0);
      end
      presetn = 1'b1;
      @(negedge pclk);
      do_xfer(1'b0, 32'h104, 32'h0, 4'h0, 1, 1'b0);

      // randomized traffic
      for (int i = 0; i < 40; i++) begin
         we_r = 1'($urandom_range(0, 1));
         a    = {24'd0, 6'($urandom_range(0, 63)), 2'b00};
         if ($urandom_range(0, 7) == 0) a = 32'h400;
         if ($urandom_range(0, 9) == 0) a = a | 32'($urandom_range(1, 3));
         r = $urandom_range(0, 9);
         w = $urandom_range(0, 3);
         if (r == 8) w = TMO - 1;
         if (r == 9) w = 255;
         do_xfer(we_r, a, $urandom, 4'($urandom_range(0, 15)), w, ($urandom_range(0, 5) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
